clock_set_ctrl: RTL and testbench

- Mode/sequencing controller for the digital clock counter chain (centisecond/second counter, minute and hour counters), clocked by the 100 Hz tick.
- Runs a RUN/SET_HOUR/SET_MIN/SET_SEC state machine from debounced keys and gates the chain's count enable.
- Issues single-cycle increment/clear strobes to the hour, minute and second counters, with hold-to-repeat and an idle timeout.
- Drives per-field blink masks for the display scanner.

---
 rtl/clock_set_ctrl.sv | 170 +++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Mode/sequencing controller for the clock counter chain: RUN/SET state machine,
// field increment/clear strobes with hold-to-repeat, idle timeout and blink masks.
module clock_set_ctrl #(
  parameter int unsigned TIMEOUT_TICKS = 1000,
  parameter int unsigned BLINK_HALF    = 25,
  parameter int unsigned REPEAT_DELAY  = 50,
  parameter int unsigned REPEAT_RATE   = 10
) (
  input  logic       clk_100Hz,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_inc_hold,
  output logic       cnt_en,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       clr_sec,
  output logic [1:0] mode,
  output logic [2:0] blink_mask,
  output logic       timeout
);

  localparam int unsigned IDLE_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);
  localparam int unsigned HOLD_W  = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned RATE_W  = $clog2(REPEAT_RATE + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10,
    ST_SET_SEC  = 2'b11
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [IDLE_W-1:0]   idle_nxt;
  logic [BLINK_W-1:0]  blink_cnt;
  logic [BLINK_W-1:0]  blink_nxt;
  logic                phase;
  logic                phase_nxt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_nxt;
  logic [RATE_W-1:0]   rate_cnt;
  logic [RATE_W-1:0]   rate_nxt;
  logic                repeat_fire;
  logic                timeout_nxt;
  logic                inc_hour_nxt;
  logic                inc_min_nxt;
  logic                clr_sec_nxt;
  logic [2:0]          blink_mask_nxt;
  logic                in_set;
  logic                activity;
  logic                press;

  assign in_set   = (state != ST_RUN);
  assign activity = key_mode | key_inc | key_inc_hold;
  // A mode change in the same cycle swallows the increment key
  assign press    = in_set & key_inc & ~key_mode;

  // Next-state, counter and registered-output computation
  always_comb begin
    state_nxt      = state;
    idle_nxt       = '0;
    hold_nxt       = '0;
    rate_nxt       = '0;
    blink_nxt      = blink_cnt;
    phase_nxt      = phase;
    repeat_fire    = 1'b0;
    timeout_nxt    = 1'b0;
    inc_hour_nxt   = 1'b0;
    inc_min_nxt    = 1'b0;
    clr_sec_nxt    = 1'b0;
    blink_mask_nxt = 3'b000;

    // Idle timer runs only in SET states with no key activity
    if (in_set && !activity) begin
      if (idle_cnt == IDLE_W'(TIMEOUT_TICKS - 1)) begin
        timeout_nxt = 1'b1;
      end else begin
        idle_nxt = idle_cnt + IDLE_W'(1);
      end
    end

    // Hold-to-repeat: first strobe at REPEAT_DELAY, then every REPEAT_RATE
    if (key_inc_hold && !key_mode && (state == ST_SET_HOUR || state == ST_SET_MIN)) begin
      if (hold_cnt != HOLD_W'(REPEAT_DELAY)) begin
        hold_nxt    = hold_cnt + HOLD_W'(1);
        repeat_fire = (hold_cnt == HOLD_W'(REPEAT_DELAY - 1));
      end else begin
        hold_nxt = hold_cnt;
        if (rate_cnt == RATE_W'(REPEAT_RATE - 1)) begin
          repeat_fire = 1'b1;
        end else begin
          rate_nxt = rate_cnt + RATE_W'(1);
        end
      end
    end

    // Field strobes
    inc_hour_nxt = (state == ST_SET_HOUR) && (press || repeat_fire);
    inc_min_nxt  = (state == ST_SET_MIN)  && (press || repeat_fire);
    clr_sec_nxt  = (state == ST_SET_SEC)  && press;

    // Mode sequencing; an explicit key beats the timeout
    if (key_mode) begin
      case (state)
        ST_RUN:      state_nxt = ST_SET_HOUR;
        ST_SET_HOUR: state_nxt = ST_SET_MIN;
        ST_SET_MIN:  state_nxt = ST_SET_SEC;
        default:     state_nxt = ST_RUN;
      endcase
    end else if (timeout_nxt) begin
      state_nxt = ST_RUN;
    end

    // Blink restarts visible on entry and on every adjustment
    if (state_nxt == ST_RUN || key_mode || inc_hour_nxt || inc_min_nxt || clr_sec_nxt) begin
      blink_nxt = '0;
      phase_nxt = 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
      blink_nxt = '0;
      phase_nxt = ~phase;
    end else begin
      blink_nxt = blink_cnt + BLINK_W'(1);
    end

    case (state_nxt)
      ST_SET_HOUR: blink_mask_nxt = {phase_nxt, 2'b00};
      ST_SET_MIN:  blink_mask_nxt = {1'b0, phase_nxt, 1'b0};
      ST_SET_SEC:  blink_mask_nxt = {2'b00, phase_nxt};
      default:     blink_mask_nxt = 3'b000;
    endcase
  end

  // State, counters and outputs; synchronous reset clears everything
  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      state      <= ST_RUN;
      idle_cnt   <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b0;
      hold_cnt   <= '0;
      rate_cnt   <= '0;
      cnt_en     <= 1'b0;
      inc_hour   <= 1'b0;
      inc_min    <= 1'b0;
      clr_sec    <= 1'b0;
      mode       <= 2'b00;
      blink_mask <= 3'b000;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      idle_cnt   <= idle_nxt;
      blink_cnt  <= blink_nxt;
      phase      <= phase_nxt;
      hold_cnt   <= hold_nxt;
      rate_cnt   <= rate_nxt;
      cnt_en     <= (state_nxt == ST_RUN);
      inc_hour   <= inc_hour_nxt;
      inc_min    <= inc_min_nxt;
      clr_sec    <= clr_sec_nxt;
      mode       <= state_nxt;
      blink_mask <= blink_mask_nxt;
      timeout    <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios plus random keys
// against a cycle-level behavioural model.
module tb_clock_set_ctrl;

  localparam int TIMEOUT_TICKS = 1000;
  localparam int BLINK_HALF    = 25;
  localparam int REPEAT_DELAY  = 50;
  localparam int REPEAT_RATE   = 10;

  logic       clk_100Hz;
  logic       rst;
  logic       key_mode;
  logic       key_inc;
  logic       key_inc_hold;
  logic       cnt_en;
  logic       inc_hour;
  logic       inc_min;
  logic       clr_sec;
  logic [1:0] mode;
  logic [2:0] blink_mask;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int         m_mode  = 0;
  int         m_idle  = 0;
  int         m_hold  = 0;
  int         m_blink = 0;
  logic       e_cnt_en = 1'b0;
  logic       e_inc_hour = 1'b0;
  logic       e_inc_min = 1'b0;
  logic       e_clr_sec = 1'b0;
  logic [1:0] e_mode = 2'b00;
  logic [2:0] e_mask = 3'b000;
  logic       e_timeout = 1'b0;

  clock_set_ctrl #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .BLINK_HALF   (BLINK_HALF),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) dut (
    .clk_100Hz   (clk_100Hz),
    .rst         (rst),
    .key_mode    (key_mode),
    .key_inc     (key_inc),
    .key_inc_hold(key_inc_hold),
    .cnt_en      (cnt_en),
    .inc_hour    (inc_hour),
    .inc_min     (inc_min),
    .clr_sec     (clr_sec),
    .mode        (mode),
    .blink_mask  (blink_mask),
    .timeout     (timeout)
  );

  initial begin
    clk_100Hz = 1'b0;
    forever #5 clk_100Hz = ~clk_100Hz;
  end

  function automatic logic [9:0] dut_vec();
    return {cnt_en, inc_hour, inc_min, clr_sec, mode, blink_mask, timeout};
  endfunction

  function automatic logic [9:0] exp_vec();
    return {e_cnt_en, e_inc_hour, e_inc_min, e_clr_sec, e_mode, e_mask, e_timeout};
  endfunction

  // Reference behaviour for one clock edge, from the block's rules
  task automatic model_step(input bit r, input bit km, input bit ki, input bit kh);
    bit in_set, to, rep, press, sh, sm, ss, ph;
    int nm;
    if (r) begin
      m_mode = 0; m_idle = 0; m_hold = 0; m_blink = 0;
      e_cnt_en = 0; e_inc_hour = 0; e_inc_min = 0; e_clr_sec = 0;
      e_mode = 2'b00; e_mask = 3'b000; e_timeout = 0;
    end else begin
      in_set = (m_mode != 0);
      to = 0;
      rep = 0;
      if (in_set && !(km || ki || kh)) begin
        m_idle++;
        if (m_idle == TIMEOUT_TICKS) begin
          to = 1;
          m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
      if (kh && !km && (m_mode == 1 || m_mode == 2)) begin
        m_hold++;
        rep = (m_hold >= REPEAT_DELAY) && (((m_hold - REPEAT_DELAY) % REPEAT_RATE) == 0);
      end else begin
        m_hold = 0;
      end
      press = in_set && ki && !km;
      sh = (m_mode == 1) && (press || rep);
      sm = (m_mode == 2) && (press || rep);
      ss = (m_mode == 3) && press;
      if (km) nm = (m_mode + 1) % 4;
      else if (to) nm = 0;
      else nm = m_mode;
      if (nm == 0 || km || sh || sm || ss) m_blink = 0;
      else m_blink++;
      ph = (((m_blink / BLINK_HALF) % 2) == 1);
      m_mode = nm;
      e_mode = 2'(nm);
      e_cnt_en = (nm == 0);
      e_inc_hour = sh;
      e_inc_min = sm;
      e_clr_sec = ss;
      e_timeout = to;
      case (nm)
        1: e_mask = {ph, 2'b00};
        2: e_mask = {1'b0, ph, 1'b0};
        3: e_mask = {2'b00, ph};
        default: e_mask = 3'b000;
      endcase
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge
  task automatic step(input bit r, input bit km, input bit ki, input bit kh);
    rst = r; key_mode = km; key_inc = ki; key_inc_hold = kh;
    @(posedge clk_100Hz);
    model_step(r, km, ki, kh);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if (dut_vec() !== 10'd0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got %b expected %b", i, dut_vec(), 10'd0);
      end
    end
    step(0, 0, 0, 0);
    checks++;
    if (cnt_en !== 1'b1 || mode !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: cnt_en=%b mode=%b expected 1/00", cnt_en, mode);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_mode_cycle();
    for (int p = 0; p < 4; p++) begin
      step(0, 1, 0, 0);
      checks++;
      if (mode !== 2'((p + 1) % 4) || cnt_en !== (p == 3)) begin
        errors++;
        $display("FAIL mode_cycle p%0d: mode=%b cnt_en=%b expected %0d/%0d", p, mode, cnt_en, (p + 1) % 4, p == 3);
      end
      for (int k = 0; k < 4; k++) begin
        step(0, 0, 0, 0);
        checks++;
        if ({inc_hour, inc_min, clr_sec} !== 3'b000 || dut_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL mode_hold p%0d k%0d: got %b expected %b", p, k, dut_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_field_set();
    step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0);
    checks++;
    if (mode !== 2'b10) begin
      errors++;
      $display("FAIL field_enter_min: mode=%b expected 10", mode);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 0);
      checks++;
      if (inc_min !== 1'b1 || inc_hour !== 1'b0 || clr_sec !== 1'b0) begin
        errors++;
        $display("FAIL inc_min_pulse k%0d: inc_min=%b inc_hour=%b clr_sec=%b expected 1/0/0", k, inc_min, inc_hour, clr_sec);
      end
      step(0, 0, 0, 0);
      checks++;
      if (inc_min !== 1'b0 || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL inc_min_width k%0d: got %b expected %b", k, dut_vec(), exp_vec());
      end
      step(0, 0, 0, 0);
    end
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    checks++;
    if (clr_sec !== 1'b1 || mode !== 2'b11) begin
      errors++;
      $display("FAIL clr_sec_pulse: clr_sec=%b mode=%b expected 1/11", clr_sec, mode);
    end
    step(0, 0, 0, 0);
    checks++;
    if (clr_sec !== 1'b0) begin
      errors++;
      $display("FAIL clr_sec_width: clr_sec=%b expected 0", clr_sec);
    end
    step(0, 1, 1, 0);
    checks++;
    if (mode !== 2'b00 || {inc_hour, inc_min, clr_sec} !== 3'b000 || cnt_en !== 1'b1) begin
      errors++;
      $display("FAIL mode_beats_inc: mode=%b strobes=%b cnt_en=%b expected 00/000/1", mode, {inc_hour, inc_min, clr_sec}, cnt_en);
    end
  endtask

  task automatic test_auto_repeat();
    int hits[$];
    int exp_hits[5];
    int n_clr;
    exp_hits = '{1, 50, 60, 70, 80};
    step(0, 1, 0, 0);
    for (int c = 1; c <= 80; c++) begin
      step(0, 0, (c == 1), 1);
      if (inc_hour === 1'b1) hits.push_back(c);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL repeat_hour_model c%0d: got %b expected %b", c, dut_vec(), exp_vec());
      end
    end
    step(0, 0, 0, 0);
    checks++;
    if (hits.size() != 5) begin
      errors++;
      $display("FAIL repeat_hour_count: got %0d expected 5", hits.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (hits[i] != exp_hits[i]) begin
          errors++;
          $display("FAIL repeat_hour_pos%0d: got cycle %0d expected %0d", i, hits[i], exp_hits[i]);
        end
      end
    end
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    n_clr = 0;
    for (int c = 1; c <= 80; c++) begin
      step(0, 0, (c == 1), 1);
      if (clr_sec === 1'b1) n_clr++;
    end
    checks++;
    if (n_clr != 1 || mode !== 2'b11) begin
      errors++;
      $display("FAIL repeat_sec_none: clr_sec pulses=%0d mode=%b expected 1/11", n_clr, mode);
    end
    step(0, 1, 0, 0);
  endtask

  task automatic test_timeout();
    step(0, 1, 0, 0);
    for (int k = 1; k <= 1001; k++) begin
      step(0, 0, 0, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL timeout_model k%0d: got %b expected %b", k, dut_vec(), exp_vec());
      end
      if (k == 24 || k == 50) begin
        checks++;
        if (blink_mask !== 3'b000) begin
          errors++;
          $display("FAIL blink_visible k%0d: got %b expected 000", k, blink_mask);
        end
      end
      if (k == 25) begin
        checks++;
        if (blink_mask !== 3'b100) begin
          errors++;
          $display("FAIL blink_blank k%0d: got %b expected 100", k, blink_mask);
        end
      end
      if (k == 999) begin
        checks++;
        if (mode !== 2'b01 || timeout !== 1'b0) begin
          errors++;
          $display("FAIL timeout_early: mode=%b timeout=%b expected 01/0", mode, timeout);
        end
      end
      if (k == 1000) begin
        checks++;
        if (mode !== 2'b00 || timeout !== 1'b1 || cnt_en !== 1'b1) begin
          errors++;
          $display("FAIL timeout_fire: mode=%b timeout=%b cnt_en=%b expected 00/1/1", mode, timeout, cnt_en);
        end
      end
      if (k == 1001) begin
        checks++;
        if (timeout !== 1'b0) begin
          errors++;
          $display("FAIL timeout_width: timeout=%b expected 0", timeout);
        end
      end
    end
    // A key at idle cycle 999 must restart the count
    step(0, 1, 0, 0);
    for (int k = 1; k <= 998; k++) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    checks++;
    if (inc_hour !== 1'b1 || mode !== 2'b01) begin
      errors++;
      $display("FAIL restart_key: inc_hour=%b mode=%b expected 1/01", inc_hour, mode);
    end
    for (int j = 1; j <= 1000; j++) begin
      step(0, 0, 0, 0);
      if (j == 999) begin
        checks++;
        if (mode !== 2'b01 || timeout !== 1'b0) begin
          errors++;
          $display("FAIL restart_early: mode=%b timeout=%b expected 01/0", mode, timeout);
        end
      end
      if (j == 1000) begin
        checks++;
        if (mode !== 2'b00 || timeout !== 1'b1) begin
          errors++;
          $display("FAIL restart_fire: mode=%b timeout=%b expected 00/1", mode, timeout);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int early;
    step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0);
    for (int c = 1; c <= 59; c++) begin
      step(0, 0, (c == 1), 1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL pre_reset_model c%0d: got %b expected %b", c, dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 1);
      checks++;
      if (dut_vec() !== 10'd0) begin
        errors++;
        $display("FAIL reset_mid cyc%0d: got %b expected %b", i, dut_vec(), 10'd0);
      end
    end
    step(0, 0, 0, 1);
    checks++;
    if (cnt_en !== 1'b1 || mode !== 2'b00 || inc_min !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: cnt_en=%b mode=%b inc_min=%b expected 1/00/0", cnt_en, mode, inc_min);
    end
    step(0, 1, 0, 1);
    early = 0;
    for (int c = 1; c <= 50; c++) begin
      step(0, 0, 0, 1);
      if (c < 50 && inc_hour === 1'b1) early++;
      if (c == 50) begin
        checks++;
        if (inc_hour !== 1'b1 || early != 0) begin
          errors++;
          $display("FAIL hold_restart: inc_hour@50=%b early=%0d expected 1/0", inc_hour, early);
        end
      end
    end
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec() || mode !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_tail: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bit hold_lvl;
    bit r, km, ki;
    hold_lvl = 0;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 499) == 0);
      km = ($urandom_range(0, 39) == 0);
      ki = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 29) == 0) hold_lvl = ~hold_lvl;
      step(r, km, ki, hold_lvl);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random n%0d: got %b expected %b", n, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; key_mode = 1'b0; key_inc = 1'b0; key_inc_hold = 1'b0;
    test_reset();
    test_mode_cycle();
    test_field_set();
    test_auto_repeat();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
